down_cnt: RTL and testbench

DOWN_CNT -- requirements
Module: down_cnt

---
 rtl/cnt_pkg.sv | 18 +
 rtl/dcnt4.sv | 28 ++
 rtl/down_cnt.sv | 98 +++++++++
 tb/tb_down_cnt.sv | 128 ++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cnt_pkg
//  Brief    : Shared constants for the down_cnt counter slice: state encoding
//             and nibble width of the borrow-chain decrementer.
//  Revision : 1.0 - initial release
// ============================================================================
package cnt_pkg;

    // Nibble width of one borrow-chain stage
    localparam int NIB = 4;

    // Two-state controller encoding
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

endpackage : cnt_pkg
`default_nettype wire

// File: rtl/dcnt4.sv
`default_nettype none
// ============================================================================
//  Module   : dcnt4
//  Brief    : 4-bit combinational nibble decrementer with borrow-in and
//             borrow-out. The nibble decrements only when borrow-in is high;
//             borrow-out propagates when this nibble is about to wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module dcnt4
    import cnt_pkg::*;
(
    input  logic [NIB-1:0] i_nib,
    input  logic           i_bin,
    output logic [NIB-1:0] o_nib,
    output logic           o_bout
);

    localparam logic [NIB-1:0] c_zero = '0;
    localparam logic [NIB-1:0] c_one  = {{(NIB-1){1'b0}}, 1'b1};

    // Decrement on borrow-in; a zero nibble borrows from the next stage up
    always_comb begin
        o_nib  = i_bin ? (i_nib - c_one) : i_nib;
        o_bout = i_bin & (i_nib == c_zero);
    end

endmodule : dcnt4
`default_nettype wire

// File: rtl/down_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : down_cnt
//  Brief    : Presettable synchronous down counter with cascade-style count
//             enables (CET & CEP), optional auto-reload and a registered
//             terminal-count pulse. The decrement is a nibble borrow chain.
//  Revision : 1.0 - initial release
// ============================================================================
module down_cnt
    import cnt_pkg::*;
#(
    // Counter width in bits; must be a multiple of 4 and at least 4
    parameter int WIDTH = 8
)
(
    input  logic             CP,
    input  logic             MR,
    input  logic             PE,
    input  logic             CET,
    input  logic             CEP,
    input  logic             ARL,
    input  logic [WIDTH-1:0] P,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             BUSY
);

    localparam int               NUM_NIB = WIDTH / NIB;
    localparam logic [WIDTH-1:0] c_zero  = '0;
    localparam logic [WIDTH-1:0] c_one   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rld;
    logic             r_tc;

    logic             w_ce;
    logic [WIDTH-1:0] w_q_dec;
    logic [NUM_NIB:0] w_borrow;
    logic             w_underflow;
    logic             w_terminal;

    assign w_ce        = CET & CEP;
    assign w_borrow[0] = w_ce;
    // Borrow out of the top nibble means Q was zero; never wrap to all-ones
    assign w_underflow = w_borrow[NUM_NIB];
    assign w_terminal  = (r_q == c_one);

    generate
        for (genvar k = 0; k < NUM_NIB; k++) begin : g_nib
            dcnt4 u_dcnt4 (
                .i_nib  (r_q[k*NIB +: NIB]),
                .i_bin  (w_borrow[k]),
                .o_nib  (w_q_dec[k*NIB +: NIB]),
                .o_bout (w_borrow[k+1])
            );
        end
    endgenerate

    // State, count, reload and terminal-count registers: reset > load > count > hold
    always_ff @(posedge CP) begin
        if (MR) begin
            r_state <= IDLE;
            r_q     <= c_zero;
            r_rld   <= c_zero;
            r_tc    <= 1'b0;
        end else if (!PE) begin
            r_q     <= P;
            r_rld   <= P;
            r_tc    <= 1'b0;
            r_state <= (P != c_zero) ? RUN : IDLE;
        end else if ((r_state == RUN) && w_ce) begin
            if (w_terminal) begin
                // ARL only matters here, on the terminal decrement
                r_tc <= 1'b1;
                if (ARL) begin
                    r_q <= r_rld;
                end else begin
                    r_q     <= c_zero;
                    r_state <= IDLE;
                end
            end else begin
                r_tc <= 1'b0;
                if (!w_underflow) begin
                    r_q <= w_q_dec;
                end
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign Q    = r_q;
    assign TC   = r_tc;
    assign BUSY = (r_state == RUN);

endmodule : down_cnt
`default_nettype wire

// File: tb/tb_down_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_down_cnt
//  Brief    : Directed self-checking bench for down_cnt (WIDTH = 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_down_cnt;

    logic       CP;
    logic       MR;
    logic       PE;
    logic       CET;
    logic       CEP;
    logic       ARL;
    logic [7:0] P;
    logic [7:0] Q;
    logic       TC;
    logic       BUSY;

    int n_tests;
    int n_fail;

    down_cnt #(.WIDTH(8)) dut (
        .CP   (CP),
        .MR   (MR),
        .PE   (PE),
        .CET  (CET),
        .CEP  (CEP),
        .ARL  (ARL),
        .P    (P),
        .Q    (Q),
        .TC   (TC),
        .BUSY (BUSY)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    // Apply inputs, take one rising edge, then settle before sampling
    task automatic step(input logic mr, input logic pe, input logic cet,
                        input logic cep, input logic arl, input logic [7:0] p);
        MR  = mr;
        PE  = pe;
        CET = cet;
        CEP = cep;
        ARL = arl;
        P   = p;
        @(posedge CP);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] q_exp,
                       input logic tc_exp, input logic busy_exp);
        n_tests++;
        assert (Q === q_exp) else begin
            n_fail++;
            $error("FAIL %s.Q observed=%h expected=%h", tag, Q, q_exp);
        end
        n_tests++;
        assert (TC === tc_exp) else begin
            n_fail++;
            $error("FAIL %s.TC observed=%b expected=%b", tag, TC, tc_exp);
        end
        n_tests++;
        assert (BUSY === busy_exp) else begin
            n_fail++;
            $error("FAIL %s.BUSY observed=%b expected=%b", tag, BUSY, busy_exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        MR = 1'b1; PE = 1'b1; CET = 1'b0; CEP = 1'b0; ARL = 1'b0; P = 8'h00;
        #2;

        // Reset
        step(1, 1, 0, 0, 0, 8'h00); chk("rst",      8'h00, 0, 0);

        // One-shot count from 5
        step(0, 0, 0, 0, 0, 8'h05); chk("os_load",  8'h05, 0, 1);
        step(0, 1, 1, 1, 0, 8'h00); chk("os_4",     8'h04, 0, 1);
        step(0, 1, 1, 1, 0, 8'h00); chk("os_3",     8'h03, 0, 1);
        step(0, 1, 1, 1, 0, 8'h00); chk("os_2",     8'h02, 0, 1);
        step(0, 1, 1, 1, 0, 8'h00); chk("os_1",     8'h01, 0, 1);
        step(0, 1, 1, 1, 0, 8'h00); chk("os_0",     8'h00, 1, 0);
        step(0, 1, 1, 1, 0, 8'h00); chk("os_hold",  8'h00, 0, 0);

        // Auto-reload from 3
        step(0, 0, 0, 0, 1, 8'h03); chk("ar_load",  8'h03, 0, 1);
        step(0, 1, 1, 1, 1, 8'h00); chk("ar_2a",    8'h02, 0, 1);
        step(0, 1, 1, 1, 1, 8'h00); chk("ar_1a",    8'h01, 0, 1);
        step(0, 1, 1, 1, 1, 8'h00); chk("ar_rld1",  8'h03, 1, 1);
        step(0, 1, 1, 1, 1, 8'h00); chk("ar_2b",    8'h02, 0, 1);
        step(0, 1, 1, 1, 1, 8'h00); chk("ar_1b",    8'h01, 0, 1);
        step(0, 1, 1, 1, 1, 8'h00); chk("ar_rld2",  8'h03, 1, 1);

        // Nibble borrow with CEP gating, then CET gating
        step(0, 0, 0, 0, 0, 8'h10); chk("nb_load",  8'h10, 0, 1);
        step(0, 1, 1, 1, 0, 8'h00); chk("nb_0f",    8'h0F, 0, 1);
        step(0, 1, 1, 0, 0, 8'h00); chk("nb_cep0",  8'h0F, 0, 1);
        step(0, 1, 1, 1, 0, 8'h00); chk("nb_0e",    8'h0E, 0, 1);
        step(0, 1, 0, 1, 0, 8'h00); chk("nb_cet0",  8'h0E, 0, 1);

        // Load wins over a terminal decrement
        step(0, 0, 0, 0, 0, 8'h01); chk("ld_q1",    8'h01, 0, 1);
        step(0, 0, 1, 1, 0, 8'h22); chk("ld_term",  8'h22, 0, 1);

        // Reset wins over a load mid-count; then load of zero stays IDLE
        step(0, 0, 0, 0, 0, 8'h40); chk("mr_load",  8'h40, 0, 1);
        step(1, 0, 1, 1, 1, 8'h55); chk("mr_abort", 8'h00, 0, 0);
        step(0, 0, 0, 0, 0, 8'h00); chk("ld_zero",  8'h00, 0, 0);
        step(0, 1, 1, 1, 0, 8'h00); chk("idle_ce1", 8'h00, 0, 0);
        step(0, 1, 1, 1, 1, 8'h00); chk("idle_ce2", 8'h00, 0, 0);

        // Auto-reload with N=1: TC every enabled cycle
        step(0, 0, 0, 0, 1, 8'h01); chk("n1_load",  8'h01, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 1, 1, 8'h00); chk("n1_cyc", 8'h01, 1, 1);
        end
        step(0, 1, 1, 0, 1, 8'h00); chk("n1_stop",  8'h01, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_down_cnt
`default_nettype wire
